// File: rtl/scoreboard.sv
// In-order tracking buffer between issue and commit: decode allocates at the tail, FUs write back by trans_id, commit retires from the head.
// Optional macro SB_WB_BYPASS_EN forwards a same-cycle writeback to the head straight onto the commit port.
package scoreboard_pkg;
    localparam int SB_NR_ENTRIES    = 4;
    localparam int SB_NR_WB_PORTS   = 2;
    localparam int SB_TRANS_ID_BITS = 2;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [SB_TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]                  fu;
        logic [6:0]                  op;
        logic [4:0]                  rs1;
        logic [4:0]                  rs2;
        logic [4:0]                  rd;
        logic [63:0]                 result;
        logic                        valid;
        logic                        use_imm;
        logic                        use_pc;
        exception_t                  ex;
        logic                        is_compressed;
    } scoreboard_entry_t;
endpackage

module scoreboard #(
    parameter int NR_ENTRIES    = scoreboard_pkg::SB_NR_ENTRIES,
    parameter int NR_WB_PORTS   = scoreboard_pkg::SB_NR_WB_PORTS,
    parameter int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              flush_i,
    output logic                                              full_o,
    input  scoreboard_pkg::scoreboard_entry_t                 decoded_instr_i,
    input  logic                                              decoded_instr_valid_i,
    output logic                                              decoded_instr_ack_o,
    output logic [TRANS_ID_BITS-1:0]                          issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                            wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]         wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]                      wb_data_i,
    input  scoreboard_pkg::exception_t [NR_WB_PORTS-1:0]      wb_ex_i,
    output scoreboard_pkg::scoreboard_entry_t                 commit_instr_o,
    output logic                                              commit_valid_o,
    input  logic                                              commit_ack_i
);
    localparam int CNT_BITS = TRANS_ID_BITS + 1;
    localparam int TID_W    = scoreboard_pkg::SB_TRANS_ID_BITS;

    typedef logic [TRANS_ID_BITS-1:0] ptr_t;

    scoreboard_pkg::scoreboard_entry_t mem_q [NR_ENTRIES];
    scoreboard_pkg::scoreboard_entry_t mem_d [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] occ_q, occ_d;
    ptr_t                  head_q, head_d;
    ptr_t                  tail_q, tail_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  alloc;
    logic                  retire;

    // Both handshakes are valid/ack: a transfer happens in exactly the cycle where
    // the request (decoded_instr_valid_i / commit_valid_o) and its acceptance
    // (decoded_instr_ack_o / commit_ack_i) are high together; ack alone does nothing.
    assign full_o              = (cnt_q == CNT_BITS'(NR_ENTRIES));
    assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
    assign issue_trans_id_o    = tail_q;
    assign alloc               = decoded_instr_ack_o;
    assign retire              = commit_ack_i & commit_valid_o & ~flush_i;

`ifdef SB_WB_BYPASS_EN
    logic                       head_hit;
    logic [63:0]                head_wb_data;
    scoreboard_pkg::exception_t head_wb_ex;

    // Descending scan so the lowest-index port is the last (winning) assignment.
    always_comb begin
        head_hit     = 1'b0;
        head_wb_data = '0;
        head_wb_ex   = '0;
        for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid_i[p] && (wb_trans_id_i[p] == head_q)) begin
                head_hit     = 1'b1;
                head_wb_data = wb_data_i[p];
                head_wb_ex   = wb_ex_i[p];
            end
        end
    end

    always_comb begin
        commit_instr_o = mem_q[head_q];
        commit_valid_o = occ_q[head_q] & mem_q[head_q].valid;
        if (occ_q[head_q] && head_hit) begin
            commit_valid_o        = 1'b1;
            commit_instr_o.result = head_wb_data;
            if (head_wb_ex.valid) begin
                commit_instr_o.ex = head_wb_ex;
            end
        end
    end
`else
    assign commit_instr_o = mem_q[head_q];
    assign commit_valid_o = occ_q[head_q] & mem_q[head_q].valid;
`endif

    always_comb begin
        mem_d  = mem_q;
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_d[i].valid = 1'b0;
            end
            occ_d  = '0;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            // A head entry retiring this cycle must not absorb the writeback.
            for (int i = 0; i < NR_ENTRIES; i++) begin
                for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
                    if (wb_valid_i[p] && (wb_trans_id_i[p] == ptr_t'(i)) && occ_q[i]
                        && !(retire && (ptr_t'(i) == head_q))) begin
                        mem_d[i].result = wb_data_i[p];
                        mem_d[i].valid  = 1'b1;
                        mem_d[i].ex     = wb_ex_i[p].valid ? wb_ex_i[p] : mem_q[i].ex;
                    end
                end
            end
            if (retire) begin
                occ_d[head_q]       = 1'b0;
                mem_d[head_q].valid = 1'b0;
                head_d              = head_q + ptr_t'(1);
            end
            // Allocation overrides any writeback aimed at the same slot.
            if (alloc) begin
                mem_d[tail_q]          = decoded_instr_i;
                mem_d[tail_q].trans_id = TID_W'(tail_q);
                mem_d[tail_q].valid    = decoded_instr_i.ex.valid;
                occ_d[tail_q]          = 1'b1;
                tail_d                 = tail_q + ptr_t'(1);
            end
            cnt_d = cnt_q + CNT_BITS'(alloc) - CNT_BITS'(retire);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_scoreboard.sv
// Bench for scoreboard: directed scenarios plus random traffic against an in-order queue model.
module tb_scoreboard;
    import scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                    flush;
    logic                    full;
    scoreboard_entry_t       ent;
    logic                    dv;
    logic                    ack;
    logic [1:0]              issue_id;
    logic [1:0]              wb_valid;
    logic [1:0][1:0]         wb_id;
    logic [1:0][63:0]        wb_data;
    exception_t [1:0]        wb_ex;
    scoreboard_entry_t       commit_instr;
    logic                    commit_valid;
    logic                    commit_ack;

    scoreboard dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .flush_i               (flush),
        .full_o                (full),
        .decoded_instr_i       (ent),
        .decoded_instr_valid_i (dv),
        .decoded_instr_ack_o   (ack),
        .issue_trans_id_o      (issue_id),
        .wb_valid_i            (wb_valid),
        .wb_trans_id_i         (wb_id),
        .wb_data_i             (wb_data),
        .wb_ex_i               (wb_ex),
        .commit_instr_o        (commit_instr),
        .commit_valid_o        (commit_valid),
        .commit_ack_i          (commit_ack)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: in-flight instructions in program order, looked up by trans_id.
    scoreboard_entry_t model_q[$];
    int                next_id;
    logic              exp_ack;
    logic              exp_retire;

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exception_t rand_ex();
        exception_t e;
        e.cause = {$urandom(), $urandom()};
        e.tval  = {$urandom(), $urandom()};
        e.valid = ($urandom_range(0, 7) == 0);
        return e;
    endfunction

    function automatic scoreboard_entry_t rand_entry(bit allow_ex);
        logic [255:0] r;
        scoreboard_entry_t e;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        e = r[224:0];
        e.ex.valid = allow_ex && ($urandom_range(0, 7) == 0);
        return e;
    endfunction

    task automatic idle_inputs();
        dv         = 1'b0;
        ent        = '0;
        flush      = 1'b0;
        commit_ack = 1'b0;
        wb_valid   = '0;
        wb_id      = '0;
        wb_data    = '0;
        wb_ex      = '0;
    endtask

    task automatic set_wb(int p, logic [1:0] id, logic [63:0] data);
        wb_valid[p] = 1'b1;
        wb_id[p]    = id;
        wb_data[p]  = data;
        wb_ex[p]    = '0;
    endtask

    // Oldest instruction as commit should present it this cycle.
    task automatic model_head(output bit cv, output scoreboard_entry_t e);
        cv = 1'b0;
        e  = '0;
        if (model_q.size() > 0) begin
            e  = model_q[0];
            cv = e.valid;
`ifdef SB_WB_BYPASS_EN
            for (int p = 0; p < 2; p++) begin
                if (wb_valid[p] && wb_id[p] == e.trans_id) begin
                    cv       = 1'b1;
                    e.result = wb_data[p];
                    if (wb_ex[p].valid) e.ex = wb_ex[p];
                    break;
                end
            end
`endif
        end
    endtask

    task automatic settle_and_check();
        bit                cv;
        scoreboard_entry_t he;
        bit                exp_full;
        #1;
        model_head(cv, he);
        exp_full   = (model_q.size() == 4);
        exp_ack    = dv && !exp_full && !flush;
        exp_retire = commit_ack && cv && !flush;
        check("full", 256'(full), 256'(exp_full));
        check("alloc_ack", 256'(ack), 256'(exp_ack));
        check("issue_id", 256'(issue_id), 256'(next_id));
        check("commit_valid", 256'(commit_valid), 256'(cv));
        if (cv) check("commit_instr", 256'(commit_instr), 256'(he));
    endtask

    task automatic advance();
        scoreboard_entry_t e;
        @(posedge clk);
        if (flush) begin
            model_q.delete();
            next_id = 0;
        end else begin
            for (int i = 0; i < model_q.size(); i++) begin
                if (exp_retire && i == 0) continue;
                for (int p = 0; p < 2; p++) begin
                    if (wb_valid[p] && wb_id[p] == model_q[i].trans_id) begin
                        model_q[i].result = wb_data[p];
                        model_q[i].valid  = 1'b1;
                        if (wb_ex[p].valid) model_q[i].ex = wb_ex[p];
                        break;
                    end
                end
            end
            if (exp_retire) void'(model_q.pop_front());
            if (exp_ack) begin
                e          = ent;
                e.trans_id = 2'(next_id);
                e.valid    = ent.ex.valid;
                model_q.push_back(e);
                next_id = (next_id + 1) % 4;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_q.delete();
        next_id = 0;
        repeat (2) @(negedge clk);
        check("rst_full", 256'(full), 256'(0));
        check("rst_ack", 256'(ack), 256'(0));
        check("rst_commit_valid", 256'(commit_valid), 256'(0));
        check("rst_commit_instr", 256'(commit_instr), 256'(0));
        check("rst_issue_id", 256'(issue_id), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic alloc_one();
        dv  = 1'b1;
        ent = rand_entry(1'b0);
        settle_and_check();
        advance();
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);

        // Fill to capacity, then a refused fifth request.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dv  = 1'b1;
            ent = rand_entry(1'b0);
            settle_and_check();
            check("fill_id", 256'(issue_id), 256'(i));
            check("fill_ack", 256'(ack), 256'(1));
            advance();
        end
        dv  = 1'b1;
        ent = rand_entry(1'b0);
        settle_and_check();
        check("full_flag", 256'(full), 256'(1));
        check("full_noack", 256'(ack), 256'(0));
        check("full_nocv", 256'(commit_valid), 256'(0));
        advance();

        // Out-of-order writeback, in-order commit.
        do_reset();
        alloc_one();
        alloc_one();
        set_wb(0, 2'd1, 64'hAA);
        settle_and_check();
        advance();
        set_wb(1, 2'd0, 64'h55);
        settle_and_check();
        advance();
        commit_ack = 1'b1;
        settle_and_check();
        check("ooo_cv0", 256'(commit_valid), 256'(1));
        check("ooo_res0", 256'(commit_instr.result), 256'(64'h55));
        advance();
        commit_ack = 1'b1;
        settle_and_check();
        check("ooo_res1", 256'(commit_instr.result), 256'(64'hAA));
        check("ooo_id1", 256'(commit_instr.trans_id), 256'(1));
        advance();

        // Both ports hit the same slot: port 0 wins.
        do_reset();
        repeat (3) alloc_one();
        set_wb(0, 2'd0, 64'h1);
        set_wb(1, 2'd1, 64'h2);
        settle_and_check();
        advance();
        set_wb(0, 2'd2, 64'h11);
        set_wb(1, 2'd2, 64'h22);
        settle_and_check();
        advance();
        repeat (2) begin
            commit_ack = 1'b1;
            settle_and_check();
            advance();
        end
        commit_ack = 1'b1;
        settle_and_check();
        check("collision_res", 256'(commit_instr.result), 256'(64'h11));
        advance();

        // Commit while full does not free a slot for the same cycle.
        do_reset();
        repeat (4) alloc_one();
        set_wb(0, 2'd0, 64'h33);
        settle_and_check();
        advance();
        dv         = 1'b1;
        ent        = rand_entry(1'b0);
        commit_ack = 1'b1;
        settle_and_check();
        check("fc_full", 256'(full), 256'(1));
        check("fc_noack", 256'(ack), 256'(0));
        check("fc_cv", 256'(commit_valid), 256'(1));
        advance();
        dv  = 1'b1;
        ent = rand_entry(1'b0);
        settle_and_check();
        check("fc_notfull", 256'(full), 256'(0));
        check("fc_ack", 256'(ack), 256'(1));
        check("fc_wrap_id", 256'(issue_id), 256'(0));
        advance();

        // Flush with a writeback in flight.
        do_reset();
        repeat (3) alloc_one();
        set_wb(0, 2'd1, 64'h44);
        flush = 1'b1;
        dv    = 1'b1;
        ent   = rand_entry(1'b0);
        settle_and_check();
        check("flush_noack", 256'(ack), 256'(0));
        advance();
        dv  = 1'b1;
        ent = rand_entry(1'b0);
        settle_and_check();
        check("flush_cv", 256'(commit_valid), 256'(0));
        check("flush_full", 256'(full), 256'(0));
        check("flush_id", 256'(issue_id), 256'(0));
        advance();
        set_wb(0, 2'd1, 64'h99);
        settle_and_check();
        advance();
        settle_and_check();
        check("flush_stale_wb", 256'(commit_valid), 256'(0));
        advance();

        // Writeback to the head with a same-cycle commit.
        do_reset();
        alloc_one();
        set_wb(0, 2'd0, 64'h7);
        commit_ack = 1'b1;
        settle_and_check();
`ifdef SB_WB_BYPASS_EN
        check("byp_cv", 256'(commit_valid), 256'(1));
        check("byp_res", 256'(commit_instr.result), 256'(64'h7));
        advance();
        settle_and_check();
        check("byp_empty", 256'(commit_valid), 256'(0));
        advance();
`else
        check("nobyp_cv0", 256'(commit_valid), 256'(0));
        advance();
        commit_ack = 1'b1;
        settle_and_check();
        check("nobyp_cv1", 256'(commit_valid), 256'(1));
        check("nobyp_res", 256'(commit_instr.result), 256'(64'h7));
        advance();
`endif

        // Random traffic.
        do_reset();
        repeat (600) begin
            dv         = ($urandom_range(0, 9) < 6);
            ent        = rand_entry(1'b1);
            commit_ack = $urandom_range(0, 1) == 1;
            flush      = ($urandom_range(0, 49) == 0);
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 9) < 4) begin
                    wb_valid[p] = 1'b1;
                    wb_id[p]    = 2'($urandom_range(0, 3));
                    wb_data[p]  = {$urandom(), $urandom()};
                    wb_ex[p]    = rand_ex();
                end
            end
            settle_and_check();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
